// File: rtl/stick_disp_pkg.sv
// Shared constants and helpers for the stick-game display driver.
// Holds the seven-segment glyphs (bit order {g,f,e,d,c,b,a}, active-high),
// the BCD converter state type and the count saturation limit.
package stick_disp_pkg;

    // Largest count that fits on the three count digits
    localparam logic [9:0] SAT_LIMIT = 10'd999;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Converter state encoding
    typedef logic [1:0] conv_state_t;
    localparam conv_state_t CONV_IDLE   = 2'd0;
    localparam conv_state_t CONV_SHIFT  = 2'd1;
    localparam conv_state_t CONV_COMMIT = 2'd2;

    function automatic logic [9:0] saturate(input logic [15:0] v);
        if (v > {6'd0, SAT_LIMIT}) begin
            return SAT_LIMIT;
        end
        return v[9:0];
    endfunction

    // Double-dabble correction applied to each BCD nibble before a shift
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One conversion: IDLE -> SHIFT (16 cycles) -> COMMIT (1 cycle) -> IDLE.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high; abandons any conversion
//   start  - load value and begin a conversion (honoured only in IDLE)
//   value  - 10-bit binary value to convert
//   busy   - high while not in IDLE
//   done   - high for the single COMMIT cycle; bcd is valid then
//   bcd    - three BCD digits {hundreds, tens, units}
module bin2bcd_seq
    import stick_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  value,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state_q, state_d;
    // {bcd digits[11:0], binary[15:0]}; binary is the value zero-extended to 16 bits
    logic [27:0] sr_q, sr_d;
    logic [27:0] sr_adj;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        sr_adj = {dd_adjust(sr_q[27:24]), dd_adjust(sr_q[23:20]),
                  dd_adjust(sr_q[19:16]), sr_q[15:0]};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    sr_d    = {12'd0, 6'd0, value};
                    cnt_d   = 4'd0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != CONV_IDLE);
    assign done = (state_q == CONV_COMMIT);
    assign bcd  = sr_q[27:16];

endmodule

// File: rtl/stick_display_driver.sv
// Four-digit multiplexed seven-segment driver for the stick game.
// Digit 3 (leftmost) shows the player ("1"/"2"), digits 2..0 the saturated
// stick count with leading-zero blanking; "donE" when the game is over.
// Optional build macro DISPLAY_BLINK_EN: an illegal move blinks the whole
// display; without it an illegal move shows a steady "E" on digit 3.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous reset, active-high
//   datain   - remaining-stick count, unsigned
//   user     - current player (0 = player 1, 1 = player 2)
//   wrong    - illegal-move flag (level)
//   finish   - game-over flag (level)
//   display  - segments {g,f,e,d,c,b,a}, active-high, registered
//   grounds  - digit enables, active-low one-hot, bit 3 leftmost, registered
module stick_display_driver
    import stick_disp_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [7:0]  BLINK_DIV   = 8'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] datain,
    input  logic        user,
    input  logic        wrong,
    input  logic        finish,
    output logic [6:0]  display,
    output logic [3:0]  grounds
);

    // ---------------- count capture and BCD conversion ----------------
    logic [9:0]  sat_val;
    logic [9:0]  captured_q;
    logic        conv_start, conv_busy, conv_done;
    logic [11:0] conv_bcd;
    logic [11:0] bcd_q;

    assign sat_val = saturate(datain);
    // Changes seen while busy are picked up once the converter is back in IDLE
    assign conv_start = !conv_busy && (sat_val != captured_q);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (sat_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // ---------------- scan timing ----------------
    logic [15:0] refresh_q, refresh_d;
    logic [1:0]  idx_q, idx_d;
    logic        refresh_tc, frame_wrap;

    always_comb begin
        refresh_tc = (refresh_q == REFRESH_DIV - 16'd1);
        refresh_d  = refresh_tc ? 16'd0 : refresh_q + 16'd1;
        idx_d      = refresh_tc ? idx_q + 2'd1 : idx_q;
        frame_wrap = refresh_tc && (idx_q == 2'd3);
    end

    // ---------------- illegal-move indication ----------------
    logic blank_all;
    logic show_err;

`ifdef DISPLAY_BLINK_EN
    logic [7:0] frame_q, frame_d;
    logic       blink_on_q, blink_on_d;
    logic       wrong_q;

    // Blink only runs while wrong is held. A fresh illegal move starts in the
    // blank half so the error shows up at once; releasing wrong restores
    // content immediately.
    always_comb begin
        frame_d    = frame_q;
        blink_on_d = blink_on_q;
        if (!wrong) begin
            frame_d    = 8'd0;
            blink_on_d = 1'b1;
        end else if (!wrong_q) begin
            frame_d    = 8'd0;
            blink_on_d = 1'b0;
        end else if (frame_wrap) begin
            if (frame_q == BLINK_DIV - 8'd1) begin
                frame_d    = 8'd0;
                blink_on_d = !blink_on_q;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= 8'd0;
            blink_on_q <= 1'b1;
            wrong_q    <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            blink_on_q <= blink_on_d;
            wrong_q    <= wrong;
        end
    end

    assign blank_all = wrong && !finish && !blink_on_d;
    assign show_err  = 1'b0;
`else
    assign blank_all = 1'b0;
    assign show_err  = wrong;
`endif

    // ---------------- digit content ----------------
    // Outputs are built from the next index so grounds and segments always
    // move together in the same registered update.
    logic [3:0] hund, tens, units;
    logic [6:0] seg_d;
    logic [3:0] grounds_d;

    assign hund  = bcd_q[11:8];
    assign tens  = bcd_q[7:4];
    assign units = bcd_q[3:0];

    always_comb begin
        seg_d = SEG_BLANK;
        unique case (idx_d)
            2'd3: begin
                if (finish) begin
                    seg_d = SEG_D;
                end else if (show_err) begin
                    seg_d = SEG_E;
                end else begin
                    seg_d = user ? SEG_2 : SEG_1;
                end
            end
            2'd2: begin
                if (finish) begin
                    seg_d = SEG_O;
                end else if (hund != 4'd0) begin
                    seg_d = seg_of_digit(hund);
                end
            end
            2'd1: begin
                if (finish) begin
                    seg_d = SEG_N;
                end else if ((hund != 4'd0) || (tens != 4'd0)) begin
                    seg_d = seg_of_digit(tens);
                end
            end
            2'd0: begin
                seg_d = finish ? SEG_E : seg_of_digit(units);
            end
        endcase
        grounds_d = ~(4'b0001 << idx_d);
        if (blank_all) begin
            grounds_d = 4'b1111;
            seg_d     = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q  <= 16'd0;
            idx_q      <= 2'd0;
            captured_q <= 10'd0;
            bcd_q      <= 12'd0;
            grounds    <= 4'b1111;
            display    <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            if (conv_start) begin
                captured_q <= sat_val;
            end
            if (conv_done) begin
                bcd_q <= conv_bcd;
            end
            grounds <= grounds_d;
            display <= seg_d;
        end
    end

endmodule

// File: doc/stick_display_driver.md
STICK_DISPLAY_DRIVER -- requirements
Module: stick_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 16'd50000, meaning clock cycles each digit is lit per scan step.
REQ-002 The block SHALL have parameter BLINK_DIV, default 8'd100, meaning full 4-digit scan frames per blink half-period.
REQ-003 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 datain  input  16  remaining-stick count from the game, unsigned binary.
REQ-007 user  input  1  current player: 0 = player 1, 1 = player 2.
REQ-008 wrong  input  1  illegal move flag, level.
REQ-009 finish  input  1  game over flag, level.
REQ-010 display  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
REQ-011 grounds  output  4  digit enables, active-low, one-hot-low, registered; bit 3 is the leftmost digit.

Function
REQ-012 The count value SHALL be saturated to 999 before conversion.
REQ-013 A sequential double-dabble converter SHALL have states IDLE, SHIFT (exactly 16 cycles), COMMIT (1 cycle); IDLE->SHIFT when the saturated datain differs from the captured value; capture occurs on that transition.
REQ-014 The displayed BCD register SHALL update only in COMMIT; latency from datain change to BCD update is 18 cycles.
REQ-015 A datain change during SHIFT SHALL NOT abort the conversion; the new value is captured on return to IDLE.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1; on terminal count the digit index advances 0->1->2->3->0.
REQ-017 grounds and display SHALL change in the same cycle, for the same digit index.
REQ-018 Normal mode: digit3 shows "1" (user=0) or "2" (user=1); digits 2..0 show hundreds, tens, units.
REQ-019 Hundreds SHALL blank when zero; tens SHALL blank when hundreds and tens are both zero; units never blank.
REQ-020 finish=1 SHALL show "donE" on digits 3..0 and override wrong and the normal mode.
REQ-021 A frame counter SHALL increment on each index wrap 3->0; at BLINK_DIV-1 it clears and the blink phase toggles.
REQ-022 While wrong=1 and finish=0 and blink phase is off, grounds SHALL be 4'b1111; with blink phase on, the normal content is shown.
REQ-023 On wrong falling, blink phase SHALL return to on and the frame counter SHALL clear within one cycle.

Reset
REQ-024 rst SHALL force grounds=4'b1111, display=7'b0000000, refresh counter=0, digit index=0, frame counter=0, blink phase=on, converter=IDLE, captured value=0, BCD=000.
REQ-025 rst asserted mid-SHIFT SHALL abandon the conversion without updating BCD.
REQ-026 After rst releases with nonzero datain, conversion SHALL start on the first post-reset cycle.

Configuration
REQ-027 With DISPLAY_BLINK_EN defined, wrong SHALL blink per REQ-021..023.
REQ-028 Without DISPLAY_BLINK_EN, the frame counter and blink phase SHALL be absent; wrong=1 shows a steady "E" on digit3 and the count on digits 2..0.

Structure
REQ-029 Package stick_disp_pkg SHALL hold the segment constants (0-9, d, o, n, E, blank), the converter state type, and the saturation limit 999.
REQ-030 The converter SHALL be sub-module bin2bcd_seq (start, 10-bit value in, busy, done, 12-bit BCD out).

Verification
REQ-031 The bench SHALL use REFRESH_DIV=4, BLINK_DIV=2.
REQ-032 Scenario: datain=100 (0x64) after rst -> BCD=0x100 after 18 cycles; scan shows "1", "1", "0", "0" on grounds 0111, 1011, 1101, 1110.
REQ-033 Scenario: datain=7, user=1 -> digits "2", blank, blank, "7".
REQ-034 Scenario: datain 100->91 at SHIFT cycle 5 -> BCD goes 100 first, then 091 after a second conversion; displays blank, "9", "1".
REQ-035 Scenario: wrong=1 (DISPLAY_BLINK_EN) -> grounds=1111 for 2 frames (32 cycles), content for 2 frames; wrong=0 -> immediate content.
REQ-036 Scenario: finish=1 with wrong=1 -> steady "donE", no blanking; rst mid-scan -> grounds=1111, display=0 the next cycle.
REQ-037 Scenario: datain=0xFFFF -> shows "999"; without DISPLAY_BLINK_EN, wrong=1 -> steady "E999".
